// File: rtl/iterative_comparator.sv
`default_nettype none
// ============================================================================
// iterative_comparator: digit-serial MSB-first signed/unsigned magnitude compare
// Revision 1.0
// ============================================================================
module iterative_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             out_gt,
  output logic             out_lt,
  output logic             out_eq
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             sign_diff;
  logic [DIGIT-1:0] digit_a;
  logic [DIGIT-1:0] digit_b;
  logic             res_gt;
  logic             res_lt;
  logic             res_eq;

  assign accept    = start && (state != S_SCAN);
  assign sign_diff = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
  // Operands shift left each SCAN cycle, so the current digit is always on top.
  assign digit_a   = a_q[WIDTH-1 -: DIGIT];
  assign digit_b   = b_q[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) next_state = sign_diff ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if ((digit_a != digit_b) || (idx == '0)) next_state = S_DONE;
      end
      S_DONE: begin
        if (accept) next_state = sign_diff ? S_DONE : S_SCAN;
        else        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SCAN);
    done = (state == S_DONE);
  end

  // Result for the transition into DONE: sign shortcut on accept, digit compare in SCAN.
  always_comb begin
    res_gt = 1'b0;
    res_lt = 1'b0;
    res_eq = 1'b0;
    if (state == S_SCAN) begin
      res_gt = (digit_a > digit_b);
      res_lt = (digit_a < digit_b);
      res_eq = (digit_a == digit_b);
    end else begin
      res_gt = b[WIDTH-1];
      res_lt = a[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      out_gt <= 1'b0;
      out_lt <= 1'b0;
      out_eq <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
        idx <= IW'(N - 1);
      end else if (state == S_SCAN) begin
        a_q <= a_q << DIGIT;
        b_q <= b_q << DIGIT;
        idx <= idx - IW'(1);
      end
      if (next_state == S_DONE) begin
        out_gt <= res_gt;
        out_lt <= res_lt;
        out_eq <= res_eq;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_comparator.sv
`default_nettype none
// Testbench for iterative_comparator: vector table plus scoreboard of expected results.
module tb_iterative_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        out_gt;
  logic        out_lt;
  logic        out_eq;

  iterative_comparator #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .out_gt(out_gt), .out_lt(out_lt), .out_eq(out_eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [2:0]  res;   // {gt, lt, eq}
    int          lat;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic launch(input vec_t v);
    exp_t e;
    a = v.a;
    b = v.b;
    signed_mode = v.sgn;
    start = 1'b1;
    e.res = v.res;
    e.lat = v.lat;
    sb.push_back(e);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input logic [2:0] prior, input bit chk_prior, input int repulse_at);
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   got = 0;
    bit   hold_ok = 1;
    exp_t e;
    @(posedge clk);
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) got = 1;
      else if (chk_prior && ({out_gt, out_lt, out_eq} != prior)) hold_ok = 0;
      if (!got && cyc == repulse_at) begin
        start = 1'b1;
        a = 32'h0;
        b = 32'h1;
        signed_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("result", int'({out_gt, out_lt, out_eq}), int'(e.res));
    check("latency", cyc, e.lat);
    check("busy_cycles", busy_cnt, (e.lat == 1) ? 0 : e.lat - 1);
    if (chk_prior) check("prior_held", int'(hold_ok), 1);
  endtask

  vec_t vecs[12];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h00000005, 32'h00000003, 1'b0, 3'b100, 9};
    vecs[1]  = '{32'hF0000000, 32'h10000000, 1'b0, 3'b100, 2};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010, 1};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 2};
    vecs[4]  = '{32'h12345678, 32'h12345678, 1'b0, 3'b001, 9};
    vecs[5]  = '{32'h12345678, 32'h12345678, 1'b1, 3'b001, 9};
    vecs[6]  = '{32'h00000002, 32'h00000007, 1'b0, 3'b010, 9};
    vecs[7]  = '{32'hFFFFFFFB, 32'hFFFFFFFD, 1'b1, 3'b010, 9};
    vecs[8]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b100, 1};
    vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 3'b010, 2};
    vecs[10] = '{32'h00100000, 32'h00200000, 1'b0, 3'b010, 4};
    vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 3'b001, 9};

    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({busy, done, out_gt, out_lt, out_eq}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i]);
      wait_done(3'b000, 0, 0);
      @(negedge clk);
      check("done_single_pulse", int'(done), 0);
    end

    // start re-pulsed mid-SCAN with different operands must be ignored
    launch(vecs[4]);
    wait_done(3'b000, 0, 3);
    @(negedge clk);

    // Back-to-back: start held in DONE, prior gt result held until the new done
    launch(vecs[0]);
    wait_done(3'b000, 0, 0);
    v = '{32'h00000002, 32'h00000007, 1'b0, 3'b010, 9};
    launch(v);
    wait_done(3'b100, 1, 0);
    @(negedge clk);

    // Reset at T+4 of a full-length compare
    a = 32'h12345678;
    b = 32'h12345678;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({busy, done, out_gt, out_lt, out_eq}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcount = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done || busy) dcount++;
      end
      check("no_activity_after_reset", dcount, 0);
    end
    v = '{32'h00000100, 32'h00000100, 1'b0, 3'b001, 9};
    launch(v);
    wait_done(3'b000, 0, 0);
    @(negedge clk);
    v = '{32'h80000000, 32'h00000000, 1'b1, 3'b010, 1};
    launch(v);
    wait_done(3'b000, 0, 0);
    @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
